// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and a 4-digit code history
module keypad_scanner #(
    parameter int SCAN_DIV     = 1024,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] digits
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       row_s1, rs;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [DB_W-1:0]  db_cnt, db_cnt_nxt;
    logic [1:0]       cur_col, cur_col_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [1:0]       low_idx;
    logic [3:0]       key_code_nxt;
    logic             key_valid_nxt, key_down_nxt;
    logic [15:0]      digits_nxt;
    logic             row_hit;

    // Rows are asynchronous to clk; only the second flop is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= 4'b1111;
            rs     <= 4'b1111;
        end else begin
            row_s1 <= row;
            rs     <= row_s1;
        end
    end

    always_comb begin
        low_idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) low_idx = 2'(i);
        end
    end

    assign row_hit = ~rs[row_idx];
    assign col     = ~(4'b0001 << cur_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            div_cnt   <= '0;
            db_cnt    <= '0;
            cur_col   <= 2'd0;
            row_idx   <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            digits    <= 16'h0000;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_cnt_nxt;
            db_cnt    <= db_cnt_nxt;
            cur_col   <= cur_col_nxt;
            row_idx   <= row_idx_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_down  <= key_down_nxt;
            digits    <= digits_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        div_cnt_nxt   = div_cnt;
        db_cnt_nxt    = db_cnt;
        cur_col_nxt   = cur_col;
        row_idx_nxt   = row_idx;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_down_nxt  = key_down;
        digits_nxt    = digits;
        unique case (state)
            SCAN: begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end else if (&rs) begin
                    cur_col_nxt = cur_col + 2'd1;
                    div_cnt_nxt = '0;
                end else begin
                    row_idx_nxt = low_idx;
                    div_cnt_nxt = '0;
                    db_cnt_nxt  = '0;
                    state_nxt   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!row_hit) begin
                    div_cnt_nxt = '0;
                    state_nxt   = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    key_code_nxt  = {row_idx, cur_col};
                    key_valid_nxt = 1'b1;
                    digits_nxt    = {digits[11:0], row_idx, cur_col};
                    key_down_nxt  = 1'b1;
                    state_nxt     = HELD;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!row_hit) begin
                    db_cnt_nxt = '0;
                    state_nxt  = RELEASE;
                end
            end
            RELEASE: begin
                // A single low sample means the key is still down: back to HELD.
                if (row_hit) begin
                    db_cnt_nxt = '0;
                    state_nxt  = HELD;
                end else if (db_cnt == DB_LAST) begin
                    key_down_nxt = 1'b0;
                    cur_col_nxt  = cur_col + 2'd1;
                    div_cnt_nxt  = '0;
                    state_nxt    = SCAN;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

endmodule
